// File: rtl/branch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_pc_unit_pkg
// Shared encodings for the branch/PC path: next-PC select codes, RISC-V
// branch funct3 codes, ALU comparison flag codes, and the PC FSM states.
// ---------------------------------------------------------------------------
package branch_pc_unit_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JAL    = 2'b10,
        NPC_JALR   = 2'b11
    } npc_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        EQUAL   = 2'b00,
        GREATER = 2'b01,
        LESS    = 2'b10,
        OTHER   = 2'b11
    } zero_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_pc_unit_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Combinational branch-taken evaluation from the branch funct3 and the ALU
// comparison flag.
//   br_type : branch funct3
//   zero    : ALU comparison flag
//   taken   : branch condition holds
// ---------------------------------------------------------------------------
module branch_cond
    import branch_pc_unit_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic [1:0] zero,
    output logic       taken
);

    // For the set-less-than forms the ALU flag reads GREATER when the SLT
    // result is 1 (A<B) and EQUAL when it is 0.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ, BR_BGE, BR_BGEU: taken = (zero == EQUAL);
            BR_BNE:                  taken = (zero != EQUAL);
            BR_BLT, BR_BLTU:         taken = (zero == GREATER);
            default:                 taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
// PC register, next-PC selection, boot/run/halt sequencing and a saturating
// count of committed redirects.
//   clk, rst_n   : clock, async active-low reset
//   stall        : hold PC, counter and state this cycle
//   npc_op       : next-PC source (PC4 / BRANCH / JAL / JALR)
//   br_type      : branch funct3
//   zero         : ALU comparison flag (used only for BRANCH)
//   alu_result   : JALR target sum (used only for JALR)
//   imm          : sign-extended branch/JAL offset
//   pc, pc_plus4 : current PC and link value
//   fetch_valid  : pc is a valid fetch address
//   branch_taken : redirect decision this cycle
//   halted       : misaligned target seen, waiting for reset
//   taken_cnt    : committed redirect count, saturating
//
// state | meaning
// BOOT  | first cycle after reset, pc = RESET_PC, no fetch
// RUN   | fetching, pc advances on every non-stalled cycle
// HALT  | misaligned target detected, pc frozen, left only by reset
// ---------------------------------------------------------------------------
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       npc_op,
    input  logic [2:0]       br_type,
    input  logic [1:0]       zero,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             branch_taken,
    output logic             halted,
    output logic [CNT_W-1:0] taken_cnt
);

    pc_state_e        state, state_nxt;
    logic [31:0]      target;
    logic [31:0]      pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cond_taken;
    logic             redirect;
    logic             misaligned;

    branch_cond u_cond (
        .br_type (br_type),
        .zero    (zero),
        .taken   (cond_taken)
    );

    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        case (npc_op)
            NPC_BRANCH: begin
                if (cond_taken) begin
                    target   = pc + imm;
                    redirect = 1'b1;
                end
            end
            NPC_JAL: begin
                target   = pc + imm;
                redirect = 1'b1;
            end
            NPC_JALR: begin
                target   = alu_result & ~32'd1;
                redirect = 1'b1;
            end
            default: begin
                target   = pc_plus4;
                redirect = 1'b0;
            end
        endcase
    end

    assign misaligned   = (target[1:0] != 2'b00);
    assign branch_taken = (state == RUN) && redirect;
    assign fetch_valid  = (state == RUN);
    assign halted       = (state == HALT);

    // Stall is checked before alignment so a stalled misaligned target
    // neither halts nor counts.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = taken_cnt;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = target;
                        if (branch_taken && (taken_cnt != {CNT_W{1'b1}})) begin
                            cnt_nxt = taken_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            HALT: state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            taken_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            taken_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

    localparam logic [1:0] OP_PC4 = 2'b00, OP_BR = 2'b01, OP_JAL = 2'b10, OP_JALR = 2'b11;
    localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101,
                           BLTU = 3'b110, BGEU = 3'b111, BX2 = 3'b010, BX3 = 3'b011;
    localparam logic [1:0] Z_EQ = 2'b00, Z_GT = 2'b01, Z_LT = 2'b10, Z_OT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  npc_op;
    logic [2:0]  br_type;
    logic [1:0]  zero;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        branch_taken;
    logic        halted;
    logic [3:0]  taken_cnt;

    branch_pc_unit #(.RESET_PC(32'h0000_1000), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .npc_op       (npc_op),
        .br_type      (br_type),
        .zero         (zero),
        .alu_result   (alu_result),
        .imm          (imm),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .branch_taken (branch_taken),
        .halted       (halted),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        bt;
        logic        fv;
        logic        h;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vec_id = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] e_pc, input logic e_bt, input logic e_fv,
                        input logic e_h, input logic [3:0] e_cnt);
        exp_t e;
        e.id  = vec_id;
        e.pc  = e_pc;
        e.bt  = e_bt;
        e.fv  = e_fv;
        e.h   = e_h;
        e.cnt = e_cnt;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Called at posedge+1: drive inputs, queue what the DUT must show this
    // cycle, then advance to the next posedge+1.
    task automatic step(input logic s, input logic [1:0] op, input logic [2:0] bt_in,
                        input logic [1:0] z, input logic [31:0] alu, input logic [31:0] im,
                        input logic [31:0] e_pc, input logic e_bt, input logic e_fv,
                        input logic e_h, input logic [3:0] e_cnt);
        stall      = s;
        npc_op     = op;
        br_type    = bt_in;
        zero       = z;
        alu_result = alu;
        imm        = im;
        push(e_pc, e_bt, e_fv, e_h, e_cnt);
        @(posedge clk);
        #1;
    endtask

    // Monitor: output sampled mid-cycle, compared against the queued entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "pc",           pc,                   e.pc);
            chk(e.id, "pc_plus4",     pc_plus4,             e.pc + 32'd4);
            chk(e.id, "branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
            chk(e.id, "fetch_valid",  {31'd0, fetch_valid},  {31'd0, e.fv});
            chk(e.id, "halted",       {31'd0, halted},       {31'd0, e.h});
            chk(e.id, "taken_cnt",    {28'd0, taken_cnt},    {28'd0, e.cnt});
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; npc_op = OP_PC4; br_type = BEQ;
        zero = Z_EQ; alu_result = '0; imm = '0;
        @(posedge clk); #1;
        // in reset: redirect request is suppressed
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h8, 32'h1000, 0, 0, 0, 4'd0);
        step(0, OP_JALR, BEQ, Z_EQ, 32'h4000, 0, 32'h1000, 0, 0, 0, 4'd0);
        rst_n = 1'b1;
        // BOOT cycle
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h8, 32'h1000, 0, 0, 0, 4'd0);
        // RUN sequential fetch; zero/alu_result ignored under PC4
        step(0, OP_PC4,  BEQ, Z_EQ, 0, 0,              32'h1000, 0, 1, 0, 4'd0);
        step(0, OP_PC4,  BNE, Z_OT, 32'hDEAD_BEEF, 2,  32'h1004, 0, 1, 0, 4'd0);
        step(0, OP_PC4,  BEQ, Z_EQ, 32'h3, 0,          32'h1008, 0, 1, 0, 4'd0);
        step(0, OP_JALR, BEQ, Z_OT, 32'h2000, 0,       32'h100C, 1, 1, 0, 4'd0);
        // BNE not taken, then taken backwards
        step(0, OP_BR,   BNE, Z_EQ, 0, 32'hFFFF_FFF0,  32'h2000, 0, 1, 0, 4'd1);
        step(0, OP_JALR, BEQ, Z_EQ, 32'h2001, 0,       32'h2004, 1, 1, 0, 4'd1);
        step(0, OP_BR,   BNE, Z_LT, 0, 32'hFFFF_FFF0,  32'h2000, 1, 1, 0, 4'd2);
        step(0, OP_JALR, BEQ, Z_EQ, 32'h0100, 0,       32'h1FF0, 1, 1, 0, 4'd3);
        // BLT taken held by two stall cycles
        step(1, OP_BR,   BLT, Z_GT, 0, 32'h8,          32'h0100, 1, 1, 0, 4'd4);
        step(1, OP_BR,   BLT, Z_GT, 0, 32'h8,          32'h0100, 1, 1, 0, 4'd4);
        step(0, OP_BR,   BLT, Z_GT, 0, 32'h8,          32'h0100, 1, 1, 0, 4'd4);
        // remaining branch types
        step(0, OP_BR,   BEQ, Z_EQ, 0, 32'h10,         32'h0108, 1, 1, 0, 4'd5);
        step(0, OP_BR,   BGE, Z_LT, 0, 32'h10,         32'h0118, 0, 1, 0, 4'd6);
        step(0, OP_BR,   BGE, Z_EQ, 0, 32'h20,         32'h011C, 1, 1, 0, 4'd6);
        step(0, OP_BR,   BLTU, Z_GT, 0, 32'hFFFF_FFFC, 32'h013C, 1, 1, 0, 4'd7);
        step(0, OP_BR,   BLTU, Z_LT, 0, 32'h40,        32'h0138, 0, 1, 0, 4'd8);
        step(0, OP_BR,   BGEU, Z_EQ, 0, 32'h4,         32'h013C, 1, 1, 0, 4'd8);
        step(0, OP_BR,   BX2, Z_EQ, 0, 32'h40,         32'h0140, 0, 1, 0, 4'd9);
        step(0, OP_BR,   BX3, Z_GT, 0, 32'h40,         32'h0144, 0, 1, 0, 4'd9);
        step(0, OP_BR,   BEQ, Z_GT, 0, 32'h40,         32'h0148, 0, 1, 0, 4'd9);
        // stalled misaligned JALR: no halt, no count
        step(1, OP_JALR, BEQ, Z_EQ, 32'h3007, 0,       32'h014C, 1, 1, 0, 4'd9);
        // JALR clears bit 0, then PC4 wraps
        step(0, OP_JALR, BEQ, Z_EQ, 32'hFFFF_FFFD, 0,  32'h014C, 1, 1, 0, 4'd9);
        step(0, OP_PC4,  BEQ, Z_EQ, 0, 0,              32'hFFFF_FFFC, 0, 1, 0, 4'd10);
        // JAL run up to and past counter saturation
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_0000, 1, 1, 0, 4'd10);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_0004, 1, 1, 0, 4'd11);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_0008, 1, 1, 0, 4'd12);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_000C, 1, 1, 0, 4'd13);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_0010, 1, 1, 0, 4'd14);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_0014, 1, 1, 0, 4'd15);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h8,          32'h0000_0018, 1, 1, 0, 4'd15);
        // misaligned JALR -> HALT with pc frozen
        step(0, OP_JALR, BEQ, Z_EQ, 32'h3007, 0,       32'h0000_0020, 1, 1, 0, 4'd15);
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h0000_0020, 0, 0, 1, 4'd15);
        step(0, OP_PC4,  BEQ, Z_EQ, 0, 0,              32'h0000_0020, 0, 0, 1, 4'd15);
        // asynchronous reset mid-cycle out of HALT
        npc_op = OP_JAL; imm = 32'h4;
        #2;
        rst_n = 1'b0;
        push(32'h1000, 0, 0, 0, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, OP_JAL,  BEQ, Z_EQ, 0, 32'h4,          32'h1000, 0, 0, 0, 4'd0);
        step(0, OP_PC4,  BEQ, Z_EQ, 0, 0,              32'h1000, 0, 1, 0, 4'd0);
        @(negedge clk); #1;
        chk(vec_id, "queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
